// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid memory
// handshake, hands instructions to decode and traps on misaligned targets.
module pc_fetch_unit #(
  parameter int             N            = 32,
  parameter logic [N-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [N-1:0]   TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic [N-1:0] pc_o,
  input  logic [N-1:0] pc_plus4_i,
  input  logic [1:0]   pc_src_i,
  input  logic [N-1:0] branch_target_i,
  input  logic [N-1:0] jalr_target_i,
  output logic [N-1:0] imem_addr_o,
  output logic         imem_req_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  instr_o,
  output logic         instr_valid_o,
  input  logic         instr_ready_i,
  output logic         misalign_trap_o,
  output logic [N-1:0] trap_addr_o,
  input  logic         trap_clr_i
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, TRAP} state_e;

  state_e       state_q;
  logic [N-1:0] pc_q;
  logic [N-1:0] trap_addr_q;
  logic [31:0]  instr_q;
  logic         instr_valid_q;
  logic         misalign_q;
  logic [N-1:0] target_d;
  logic         misaligned_d;

  // Next-PC candidate; only consumed on the HOLD handshake edge.
  always_comb begin
    case (pc_src_i)
      2'b01:   target_d = branch_target_i;
      2'b10:   target_d = jalr_target_i & {{(N-1){1'b1}}, 1'b0};
      default: target_d = pc_plus4_i;
    endcase
    misaligned_d = (target_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      trap_addr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (imem_gnt_i) begin
            if (imem_rvalid_i) begin
              instr_q       <= imem_rdata_i;
              instr_valid_q <= 1'b1;
              state_q       <= HOLD;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            instr_q       <= imem_rdata_i;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready_i) begin
            instr_valid_q <= 1'b0;
            if (!misaligned_d) begin
              pc_q    <= target_d;
              state_q <= REQ;
            end else begin
              misalign_q  <= 1'b1;
              trap_addr_q <= target_d;
              state_q     <= TRAP;
            end
          end
        end
        TRAP: begin
          if (trap_clr_i) begin
            pc_q       <= TRAP_VECTOR;
            misalign_q <= 1'b0;
            state_q    <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc_o            = pc_q;
  assign imem_addr_o     = pc_q;
  assign imem_req_o      = (state_q == REQ);
  assign instr_o         = instr_q;
  assign instr_valid_o   = instr_valid_q;
  assign misalign_trap_o = misalign_q;
  assign trap_addr_o     = trap_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit; a transaction-level model
// tracks the expected PC and trap behaviour while the bench plays the memory.
module tb_pc_fetch_unit;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] pc, pcPlus4, branchTarget, jalrTarget, imemAddr, imemRdata;
  logic [31:0] instr, trapAddr;
  logic [1:0]  pcSrc;
  logic        imemReq, imemGnt, imemRvalid, instrValid, instrReady;
  logic        misalignTrap, trapClr;

  int          compares   = 0;
  int          mismatches = 0;
  logic [31:0] expPc;

  pc_fetch_unit dut (
    .clk_i(clk), .rst_ni(rstN), .pc_o(pc), .pc_plus4_i(pcPlus4),
    .pc_src_i(pcSrc), .branch_target_i(branchTarget), .jalr_target_i(jalrTarget),
    .imem_addr_o(imemAddr), .imem_req_o(imemReq), .imem_gnt_i(imemGnt),
    .imem_rvalid_i(imemRvalid), .imem_rdata_i(imemRdata), .instr_o(instr),
    .instr_valid_o(instrValid), .instr_ready_i(instrReady),
    .misalign_trap_o(misalignTrap), .trap_addr_o(trapAddr), .trap_clr_i(trapClr)
  );

  // The external PC+4 adder.
  assign pcPlus4 = pc + 32'd4;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    if (obs !== exp) begin
      mismatches++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Plays the memory for one fetch; entered at a negedge with the DUT requesting.
  task automatic applyStimulus(input int gntDelay, input int rvDelay, input logic [31:0] data);
    for (int i = 0; i < gntDelay; i++) begin
      checkOutput("req_before_gnt", 32'(imemReq), 32'd1);
      checkOutput("addr_before_gnt", imemAddr, expPc);
      checkOutput("valid_before_gnt", 32'(instrValid), 32'd0);
      imemGnt    = 1'b0;
      imemRvalid = 1'($urandom_range(0, 1));
      imemRdata  = $urandom;
      @(negedge clk);
    end
    checkOutput("req_at_gnt", 32'(imemReq), 32'd1);
    checkOutput("addr_at_gnt", imemAddr, expPc);
    imemGnt = 1'b1;
    if (rvDelay == 0) begin
      imemRvalid = 1'b1;
      imemRdata  = data;
    end else begin
      imemRvalid = 1'b0;
      imemRdata  = $urandom;
    end
    @(negedge clk);
    imemGnt    = 1'b0;
    imemRvalid = 1'b0;
    if (rvDelay > 0) begin
      for (int i = 1; i < rvDelay; i++) begin
        checkOutput("req_in_wait", 32'(imemReq), 32'd0);
        checkOutput("valid_in_wait", 32'(instrValid), 32'd0);
        @(negedge clk);
      end
      checkOutput("req_in_wait", 32'(imemReq), 32'd0);
      imemRvalid = 1'b1;
      imemRdata  = data;
      @(negedge clk);
      imemRvalid = 1'b0;
    end
    checkOutput("instr_valid", 32'(instrValid), 32'd1);
    checkOutput("instr", instr, data);
    checkOutput("req_in_hold", 32'(imemReq), 32'd0);
  endtask

  // Stalls decode, then hands the instruction off and follows the next-PC rule.
  task automatic applyHandshake(input int stall, input logic [31:0] data, input logic [1:0] src,
                                input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] tgt;
    for (int i = 0; i < stall; i++) begin
      instrReady   = 1'b0;
      imemRvalid   = 1'($urandom_range(0, 1));
      imemRdata    = $urandom;
      trapClr      = 1'($urandom_range(0, 1));
      pcSrc        = 2'($urandom);
      branchTarget = $urandom;
      jalrTarget   = $urandom;
      @(negedge clk);
      checkOutput("stall_valid", 32'(instrValid), 32'd1);
      checkOutput("stall_instr", instr, data);
      checkOutput("stall_pc", pc, expPc);
      checkOutput("stall_req", 32'(imemReq), 32'd0);
    end
    imemRvalid   = 1'b0;
    trapClr      = 1'b0;
    instrReady   = 1'b1;
    pcSrc        = src;
    branchTarget = bt;
    jalrTarget   = jt;
    @(negedge clk);
    instrReady   = 1'b0;
    pcSrc        = 2'($urandom);
    branchTarget = $urandom;
    jalrTarget   = $urandom;
    case (src)
      2'b01:   tgt = bt;
      2'b10:   tgt = jt & 32'hFFFF_FFFE;
      default: tgt = expPc + 32'd4;
    endcase
    if (tgt % 4 == 0) begin
      expPc = tgt;
      checkOutput("next_valid", 32'(instrValid), 32'd0);
      checkOutput("next_req", 32'(imemReq), 32'd1);
      checkOutput("next_addr", imemAddr, expPc);
      checkOutput("next_notrap", 32'(misalignTrap), 32'd0);
    end else begin
      checkOutput("trap_flag", 32'(misalignTrap), 32'd1);
      checkOutput("trap_addr", trapAddr, tgt);
      checkOutput("trap_pc", pc, expPc);
      checkOutput("trap_req", 32'(imemReq), 32'd0);
      checkOutput("trap_valid", 32'(instrValid), 32'd0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        imemRvalid = 1'b1;
        imemRdata  = $urandom;
        @(negedge clk);
        checkOutput("trap_sticky", 32'(misalignTrap), 32'd1);
        checkOutput("trap_valid_hold", 32'(instrValid), 32'd0);
        checkOutput("trap_req_hold", 32'(imemReq), 32'd0);
      end
      imemRvalid = 1'b0;
      trapClr    = 1'b1;
      @(negedge clk);
      trapClr = 1'b0;
      expPc   = TRAP_VEC;
      checkOutput("trapclr_flag", 32'(misalignTrap), 32'd0);
      checkOutput("trapclr_req", 32'(imemReq), 32'd1);
      checkOutput("trapclr_addr", imemAddr, expPc);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"}, pc, 32'h0);
    checkOutput({tag, "_instr"}, instr, 32'h0);
    checkOutput({tag, "_valid"}, 32'(instrValid), 32'd0);
    checkOutput({tag, "_req"}, 32'(imemReq), 32'd0);
    checkOutput({tag, "_trap"}, 32'(misalignTrap), 32'd0);
    checkOutput({tag, "_trapaddr"}, trapAddr, 32'h0);
  endtask

  initial begin
    logic [31:0] d, bt, jt;
    rstN = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
    instrReady = 1'b0; pcSrc = 2'b00; branchTarget = '0; jalrTarget = '0; trapClr = 1'b0;
    #2;
    checkResetValues("reset");
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    expPc = 32'h0;
    checkOutput("first_req", 32'(imemReq), 32'd1);
    checkOutput("first_addr", imemAddr, expPc);

    // Zero-wait sequential stream
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      applyStimulus(0, 0, d);
      applyHandshake(0, d, 2'b00, 32'h0, 32'h0);
    end
    // Slow memory, then a stalled decode
    d = $urandom; applyStimulus(3, 2, d); applyHandshake(5, d, 2'b00, 32'h0, 32'h0);
    // Branch, then jalr with bit 0 set
    d = $urandom; applyStimulus(0, 0, d); applyHandshake(0, d, 2'b01, 32'h40, 32'h0);
    d = $urandom; applyStimulus(1, 0, d); applyHandshake(0, d, 2'b10, 32'h0, 32'h81);
    checkOutput("jalr_lands", expPc, 32'h80);
    // Misaligned branch traps and recovers at the trap vector
    d = $urandom; applyStimulus(0, 1, d); applyHandshake(1, d, 2'b01, 32'h42, 32'h0);
    // Sequential wrap at the top of the address space
    d = $urandom; applyStimulus(0, 0, d); applyHandshake(0, d, 2'b01, 32'hFFFF_FFFC, 32'h0);
    d = $urandom; applyStimulus(0, 0, d); applyHandshake(0, d, 2'b11, 32'h3, 32'h3);
    checkOutput("wrap_pc", pc, 32'h0);
    // Misaligned jalr to leave trap_addr non-zero, then reset while waiting
    d = $urandom; applyStimulus(0, 0, d); applyHandshake(0, d, 2'b10, 32'h0, 32'h0000_0206);
    d = 32'hDEAD_BEEF; applyStimulus(0, 0, d); applyHandshake(0, d, 2'b00, 32'h0, 32'h0);
    imemGnt = 1'b1; imemRvalid = 1'b0;
    @(negedge clk);
    imemGnt = 1'b0;
    checkOutput("wait_req", 32'(imemReq), 32'd0);
    rstN = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rstN = 1'b1; imemRvalid = 1'b1; imemRdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imemRvalid = 1'b0;
    expPc = 32'h0;
    checkOutput("postreset_req", 32'(imemReq), 32'd1);
    checkOutput("postreset_addr", imemAddr, expPc);
    checkOutput("postreset_valid", 32'(instrValid), 32'd0);
    checkOutput("postreset_instr", instr, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      d  = $urandom;
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1]   = 1'b0;
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d);
      applyHandshake(int'($urandom_range(0, 3)), d, 2'($urandom), bt, jt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage holding the program counter. It drives the current PC into the external PC+4 adder, consumes the adder's sum plus branch/jump targets to select the next PC, and fetches instructions from instruction memory over a request/grant/valid handshake. Fetched instructions are presented to decode with a valid/ready handshake. Misaligned control-flow targets raise a sticky trap.

## Interface
- N, 32, address/data width of PC and targets
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a trap is cleared

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- pc  out  N  current PC; feeds adder input X and instruction memory
- pc_plus4  in  N  adder output Z (pc + 4, wraps modulo 2^N)
- pc_src  in  2  next-PC select: 00 sequential, 01 branch, 10 jalr, 11 treated as 00
- branch_target  in  N  PC-relative branch/jal target
- jalr_target  in  N  register-based target; bit 0 forced to 0 before use
- imem_addr  out  N  equals pc (combinational)
- imem_req  out  1  fetch request
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  imem_rdata valid
- imem_rdata  in  32  fetched instruction word
- instr  out  32  registered instruction to decode
- instr_valid  out  1  instr is valid
- instr_ready  in  1  decode accepts instr
- misalign_trap  out  1  sticky misaligned-target flag
- trap_addr  out  N  offending target address
- trap_clr  in  1  acknowledge trap

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, TRAP.
- IDLE: entered only on reset; unconditionally to REQ next edge.
- REQ: imem_req=1. gnt && rvalid -> capture rdata into instr, HOLD. gnt only -> WAIT. rvalid without gnt ignored. Otherwise stay.
- WAIT: imem_req=0. rvalid -> capture rdata, HOLD; else stay.
- HOLD: instr_valid=1, instr stable. On instr_ready: compute next target per pc_src (sequential uses pc_plus4; branch uses branch_target; jalr uses {jalr_target[N-1:1],1'b0}).
  - Target[1:0]==00: pc <= target, instr_valid clears, state REQ.
  - Otherwise: pc unchanged, misalign_trap<=1, trap_addr<=target, instr_valid clears, state TRAP.
- pc_src and targets sampled only on the HOLD handshake edge; ignored in all other states.
- Sequential target never traps (pc always word-aligned); 0xFFFF_FFFC wraps to 0x0000_0000 without trap.
- TRAP: imem_req=0, instr_valid=0. trap_clr -> pc<=TRAP_VECTOR, misalign_trap<=0, state REQ. trap_clr outside TRAP ignored.
- rvalid arriving in IDLE, HOLD or TRAP is ignored (no capture).

## Timing
- Reset (async assert): pc=RESET_VECTOR, instr=0, instr_valid=0, imem_req=0 (combinational from state), misalign_trap=0, trap_addr=0, state IDLE. Deassertion synchronous in effect: first edge after release moves IDLE->REQ.
- imem_addr tracks pc combinationally; pc changes only on HOLD handshake edge or trap_clr edge.
- Zero-wait memory (gnt+rvalid in the REQ cycle): instr_valid high the cycle after REQ; with instr_ready tied high, one instruction per 2 cycles (REQ, HOLD).
- Each cycle of gnt delay or rvalid delay adds one cycle of latency.
- imem_req held high, pc stable, until gnt; request never withdrawn.
- Trap: misalign_trap rises the cycle after the handshake edge, stays until the edge sampling trap_clr in TRAP; REQ with pc=TRAP_VECTOR follows that edge.
- Reset mid-transaction: state returns to IDLE immediately; a late rvalid after release is not captured.

## Test plan
- Reset then zero-wait memory, instr_ready=1, pc_src=00: imem_addr sequence 0x0,0x4,0x8; instr_valid pulses every 2 cycles with rdata.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt: imem_req high 4 cycles with pc constant, instr_valid rises cycle after rvalid, instr equals rdata.
- HOLD with instr_ready=0 for 5 cycles: instr and instr_valid stable, pc stable, imem_req=0; release -> pc=0x4.
- pc_src=01 branch_target=0x40, then pc_src=10 jalr_target=0x81: next fetches at 0x40 then 0x80, no trap.
- pc_src=01 branch_target=0x42: misalign_trap=1, trap_addr=0x42, pc unchanged, no requests; trap_clr -> fetch at TRAP_VECTOR 0x100, flag cleared.
- Assert rst_n=0 while in WAIT, release, then pulse rvalid: outputs at reset values, rvalid ignored, fetch restarts at 0x0.
